// File: rtl/conv_layer_ctrl_param_if.sv
// Control/status bundle between the convolution layer sequencer and its datapath.
// The sequencer connects through the slave modport.
interface conv_layer_ctrl_param_if #(
  parameter int NUM_FILT = 2
);
  localparam int FW = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

  logic          start;
  logic          doneAdr;
  logic          macDone;
  logic          emptyTemp;
  logic [1:0]    sel;
  logic          ldAdr;
  logic          rstX;
  logic          reMem;
  logic          weMem;
  logic          WEFilter;
  logic          REFilter;
  logic          rstFilter;
  logic          WETemp;
  logic          RETemp;
  logic          rstTemp;
  logic          WEview;
  logic          REview;
  logic          enCalc;
  logic          rstCalc;
  logic          ldWR;
  logic          lastWR;
  logic          rstWR;
  logic          done;
  logic          busy;
  logic [FW-1:0] filtIdx;

  modport master (
    output start, doneAdr, macDone, emptyTemp,
    input  sel, ldAdr, rstX, reMem, weMem, WEFilter, REFilter, rstFilter,
           WETemp, RETemp, rstTemp, WEview, REview, enCalc, rstCalc,
           ldWR, lastWR, rstWR, done, busy, filtIdx
  );

  modport slave (
    input  start, doneAdr, macDone, emptyTemp,
    output sel, ldAdr, rstX, reMem, weMem, WEFilter, REFilter, rstFilter,
           WETemp, RETemp, rstTemp, WEview, REview, enCalc, rstCalc,
           ldWR, lastWR, rstWR, done, busy, filtIdx
  );
endinterface

// File: rtl/conv_layer_ctrl_param.sv
// Sequencer for one convolution layer: loads each filter, streams windows through
// the MAC, packs results into memory words and steps through NUM_FILT filters.
module conv_layer_ctrl_param #(
  parameter int FILT_DEPTH = 9,
  parameter int WIN_DEPTH  = 9,
  parameter int WR_SLOTS   = 4,
  parameter int NUM_FILT   = 2,
  parameter int CW         = 8
) (
  input logic                    clk,
  input logic                    rst,
  conv_layer_ctrl_param_if.slave bus
);
  localparam int FW = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam logic [CW-1:0] FD_LAST = CW'(FILT_DEPTH - 1);
  localparam logic [CW-1:0] WD_LAST = CW'(WIN_DEPTH - 1);
  localparam logic [CW-1:0] WS_LAST = CW'(WR_SLOTS - 1);
  localparam logic [FW-1:0] NF_LAST = FW'(NUM_FILT - 1);

  typedef enum logic [4:0] {
    IDLE, INIT, LOAD_F, RST_X, LOAD_T, POP, ARM, MAC, CHK, PACK,
    WRITE, CLR, ADV, REFILL, LAST, FLUSH, NEXTF, RELOAD, DONE
  } state_t;

  state_t        state;
  state_t        next;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] wcnt;
  logic [FW-1:0] filt_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Counters only move in the states that own them and return to zero on their last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt     <= '0;
      tcnt     <= '0;
      wcnt     <= '0;
      filt_idx <= '0;
    end else begin
      case (state)
        INIT: begin
          fcnt     <= '0;
          tcnt     <= '0;
          wcnt     <= '0;
          filt_idx <= '0;
        end
        LOAD_F: fcnt <= (fcnt == FD_LAST) ? '0 : fcnt + 1'b1;
        LOAD_T: tcnt <= (tcnt == WD_LAST) ? '0 : tcnt + 1'b1;
        PACK:   wcnt <= (wcnt == WS_LAST) ? '0 : wcnt + 1'b1;
        FLUSH:  wcnt <= '0;
        NEXTF:  if (filt_idx != NF_LAST) filt_idx <= filt_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.filtIdx = filt_idx;

  always_comb begin
    next          = state;
    bus.sel       = 2'b11;
    bus.ldAdr     = 1'b0;
    bus.rstX      = 1'b0;
    bus.reMem     = 1'b0;
    bus.weMem     = 1'b0;
    bus.WEFilter  = 1'b0;
    bus.REFilter  = 1'b0;
    bus.rstFilter = 1'b0;
    bus.WETemp    = 1'b0;
    bus.RETemp    = 1'b0;
    bus.rstTemp   = 1'b0;
    bus.WEview    = 1'b0;
    bus.REview    = 1'b0;
    bus.enCalc    = 1'b0;
    bus.rstCalc   = 1'b0;
    bus.ldWR      = 1'b0;
    bus.lastWR    = 1'b0;
    bus.rstWR     = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: if (bus.start) next = INIT;
      INIT: begin
        bus.rstCalc = 1'b1;
        bus.rstTemp = 1'b1;
        bus.rstWR   = 1'b1;
        bus.ldAdr   = 1'b1;
        next        = LOAD_F;
      end
      LOAD_F: begin
        bus.WEFilter = 1'b1;
        bus.reMem    = 1'b1;
        bus.sel      = 2'b01;
        if (fcnt == FD_LAST) next = RST_X;
      end
      RST_X: begin
        bus.rstX = 1'b1;
        bus.sel  = 2'b00;
        next     = LOAD_T;
      end
      LOAD_T: begin
        bus.WETemp = 1'b1;
        bus.reMem  = 1'b1;
        bus.sel    = 2'b00;
        if (tcnt == WD_LAST) next = POP;
      end
      POP: begin
        bus.RETemp  = 1'b1;
        bus.rstCalc = 1'b1;
        next        = ARM;
      end
      ARM: begin
        bus.WEview    = 1'b1;
        bus.rstFilter = 1'b1;
        next          = MAC;
      end
      MAC: begin
        bus.enCalc   = 1'b1;
        bus.REview   = 1'b1;
        bus.REFilter = 1'b1;
        if (bus.macDone) next = CHK;
      end
      CHK: next = bus.doneAdr ? LAST : PACK;
      PACK: begin
        bus.ldWR = 1'b1;
        next     = (wcnt == WS_LAST) ? WRITE : ADV;
      end
      WRITE: begin
        bus.weMem = 1'b1;
        bus.sel   = 2'b10;
        next      = CLR;
      end
      CLR: begin
        bus.rstWR = 1'b1;
        next      = ADV;
      end
      ADV: next = bus.emptyTemp ? REFILL : POP;
      REFILL: begin
        bus.rstTemp = 1'b1;
        next        = RST_X;
      end
      LAST: begin
        bus.ldWR   = 1'b1;
        bus.lastWR = 1'b1;
        next       = FLUSH;
      end
      // The flush writes whatever is packed, even a partial word.
      FLUSH: begin
        bus.weMem = 1'b1;
        bus.sel   = 2'b10;
        next      = NEXTF;
      end
      NEXTF: next = (filt_idx == NF_LAST) ? DONE : RELOAD;
      RELOAD: begin
        bus.rstTemp = 1'b1;
        bus.rstWR   = 1'b1;
        bus.rstCalc = 1'b1;
        bus.ldAdr   = 1'b1;
        next        = LOAD_F;
      end
      DONE: begin
        bus.done = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_layer_ctrl_param.sv
// Randomized bench: a scenario-level model expands random layer runs into the expected
// per-cycle output trace, with ignored inputs driven randomly.
module tb_conv_layer_ctrl_param;
  localparam logic [1:0] S_WIN = 2'b00, S_FLT = 2'b01, S_WR = 2'b10, S_IDL = 2'b11;
  localparam logic [18:0] B = 19'd1, DN = 19'd2, RWR = 19'd4, LWR = 19'd8, LDWR = 19'd16,
                          RCALC = 19'd32, ENC = 19'd64, REV = 19'd128, WEV = 19'd256,
                          RTMP = 19'd512, RETMP = 19'd1024, WETMP = 19'd2048, RFLT = 19'd4096,
                          REF = 19'd8192, WEF = 19'd16384, WEM = 19'd32768, REM = 19'd65536,
                          RX = 19'd131072, LDA = 19'd262144;
  localparam logic [3:0] I_START = 4'b1000, I_DONEADR = 4'b0100, I_MAC = 4'b0010, I_EMPTY = 4'b0001;

  logic        clk;
  logic        rst;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [20:0] out_a;
  logic [20:0] out_b;

  int num_checks = 0;
  int num_errors = 0;

  logic [20:0] q_exp[$];
  int          q_idx[$];
  logic [3:0]  q_care[$];
  logic [3:0]  q_val[$];

  conv_layer_ctrl_param_if #(.NUM_FILT(2)) bus_a ();
  conv_layer_ctrl_param_if #(.NUM_FILT(1)) bus_b ();

  conv_layer_ctrl_param #(
    .FILT_DEPTH(9), .WIN_DEPTH(9), .WR_SLOTS(4), .NUM_FILT(2), .CW(8)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  conv_layer_ctrl_param #(
    .FILT_DEPTH(3), .WIN_DEPTH(4), .WR_SLOTS(1), .NUM_FILT(1), .CW(8)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  assign {bus_a.start, bus_a.doneAdr, bus_a.macDone, bus_a.emptyTemp} = in_a;
  assign {bus_b.start, bus_b.doneAdr, bus_b.macDone, bus_b.emptyTemp} = in_b;

  assign out_a = {bus_a.sel, bus_a.ldAdr, bus_a.rstX, bus_a.reMem, bus_a.weMem, bus_a.WEFilter,
                  bus_a.REFilter, bus_a.rstFilter, bus_a.WETemp, bus_a.RETemp, bus_a.rstTemp,
                  bus_a.WEview, bus_a.REview, bus_a.enCalc, bus_a.rstCalc, bus_a.ldWR,
                  bus_a.lastWR, bus_a.rstWR, bus_a.done, bus_a.busy};
  assign out_b = {bus_b.sel, bus_b.ldAdr, bus_b.rstX, bus_b.reMem, bus_b.weMem, bus_b.WEFilter,
                  bus_b.REFilter, bus_b.rstFilter, bus_b.WETemp, bus_b.RETemp, bus_b.rstTemp,
                  bus_b.WEview, bus_b.REview, bus_b.enCalc, bus_b.rstCalc, bus_b.ldWR,
                  bus_b.lastWR, bus_b.rstWR, bus_b.done, bus_b.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] cur_out(input int which);
    return (which == 0) ? out_a : out_b;
  endfunction

  function automatic int cur_idx(input int which);
    return (which == 0) ? int'(bus_a.filtIdx) : int'(bus_b.filtIdx);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [18:0] m, input int fi,
                      input logic [3:0] care, input logic [3:0] val);
    q_exp.push_back({s, m});
    q_idx.push_back(fi);
    q_care.push_back(care);
    q_val.push_back(val);
  endtask

  task automatic push_fill(input int wd, input int f, input bit mark, inout int cut_at);
    push(S_WIN, RX | B, f, 4'b0, 4'b0);
    for (int i = 0; i < wd; i++) begin
      if (mark && i == 4 && cut_at < 0) cut_at = q_exp.size();
      push(S_WIN, WETMP | REM | B, f, 4'b0, 4'b0);
    end
  endtask

  // One whole layer run: per filter a random number of windows, random MAC latency,
  // random temp exhaustion, with the address sweep ending on the last window.
  task automatic build_trace(input int fd, input int wd, input int ws, input int nf,
                             input int min_win, input bit want_cut,
                             inout int last_idx, output int cut_at);
    int  wins;
    int  lat;
    int  packed_cnt;
    bit  empty;
    cut_at = -1;
    q_exp.delete(); q_idx.delete(); q_care.delete(); q_val.delete();
    repeat ($urandom_range(1, 3)) push(S_IDL, 19'b0, last_idx, I_START, 4'b0);
    push(S_IDL, 19'b0, last_idx, I_START, I_START);
    push(S_IDL, LDA | RCALC | RTMP | RWR | B, -1, 4'b0, 4'b0);
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < fd; i++) push(S_FLT, WEF | REM | B, f, 4'b0, 4'b0);
      packed_cnt = 0;
      wins = $urandom_range(min_win, min_win + 6);
      push_fill(wd, f, want_cut && (f == nf - 1), cut_at);
      for (int n = 1; n <= wins; n++) begin
        lat = $urandom_range(0, 3);
        push(S_IDL, RETMP | RCALC | B, f, 4'b0, 4'b0);
        push(S_IDL, WEV | RFLT | B, f, 4'b0, 4'b0);
        for (int c = 0; c < lat; c++) push(S_IDL, ENC | REV | REF | B, f, I_MAC, 4'b0);
        push(S_IDL, ENC | REV | REF | B, f, I_MAC, I_MAC);
        push(S_IDL, B, f, I_DONEADR, (n == wins) ? I_DONEADR : 4'b0);
        if (n == wins) begin
          push(S_IDL, LDWR | LWR | B, f, 4'b0, 4'b0);
          push(S_WR, WEM | B, f, 4'b0, 4'b0);
          push(S_IDL, B, f, 4'b0, 4'b0);
          if (f < nf - 1) push(S_IDL, RTMP | RWR | RCALC | LDA | B, f + 1, 4'b0, 4'b0);
          else            push(S_IDL, DN | B, f, 4'b0, 4'b0);
        end else begin
          push(S_IDL, LDWR | B, f, 4'b0, 4'b0);
          packed_cnt++;
          if (packed_cnt == ws) begin
            packed_cnt = 0;
            push(S_WR, WEM | B, f, 4'b0, 4'b0);
            push(S_IDL, RWR | B, f, 4'b0, 4'b0);
          end
          empty = ($urandom_range(0, 3) == 0);
          push(S_IDL, B, f, I_EMPTY, empty ? I_EMPTY : 4'b0);
          if (empty) begin
            push(S_IDL, RTMP | B, f, 4'b0, 4'b0);
            push_fill(wd, f, 1'b0, cut_at);
          end
        end
      end
    end
    last_idx = nf - 1;
    repeat (2) push(S_IDL, 19'b0, last_idx, I_START, 4'b0);
  endtask

  task automatic apply_stimulus(input int which, input int cut_at);
    logic [3:0] v;
    for (int k = 0; k < q_exp.size(); k++) begin
      @(negedge clk);
      check_output($sformatf("dut%0d cyc%0d outputs", which, k), 32'(cur_out(which)), 32'(q_exp[k]));
      if (q_idx[k] >= 0)
        check_output($sformatf("dut%0d cyc%0d filtIdx", which, k), 32'(cur_idx(which)), 32'(q_idx[k]));
      if (k == cut_at) begin
        rst = 1'b1;
        #1;
        check_output("async reset outputs", 32'(cur_out(which)), 32'({S_IDL, 19'b0}));
        check_output("async reset filtIdx", 32'(cur_idx(which)), 32'd0);
        in_a = 4'b0;
        in_b = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("post reset outputs", 32'(cur_out(which)), 32'({S_IDL, 19'b0}));
        return;
      end
      v = (q_val[k] & q_care[k]) | (4'($urandom) & ~q_care[k]);
      if (which == 0) in_a = v;
      else            in_b = v;
    end
    in_a = 4'b0;
    in_b = 4'b0;
  endtask

  initial begin
    int cut;
    int last_a;
    int last_b;
    rst  = 1'b1;
    in_a = 4'b0;
    in_b = 4'b0;
    repeat (3) @(negedge clk);
    check_output("reset outputs a", 32'(out_a), 32'({S_IDL, 19'b0}));
    check_output("reset outputs b", 32'(out_b), 32'({S_IDL, 19'b0}));
    check_output("reset filtIdx a", 32'(cur_idx(0)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle after reset a", 32'(out_a), 32'({S_IDL, 19'b0}));

    last_a = 0;
    for (int s = 0; s < 4; s++) begin
      build_trace(9, 9, 4, 2, (s == 0) ? 8 : 1, 1'b0, last_a, cut);
      apply_stimulus(0, cut);
    end
    build_trace(9, 9, 4, 2, 1, 1'b1, last_a, cut);
    apply_stimulus(0, cut);
    last_a = 0;
    build_trace(9, 9, 4, 2, 1, 1'b0, last_a, cut);
    apply_stimulus(0, cut);

    last_b = 0;
    for (int s = 0; s < 4; s++) begin
      build_trace(3, 4, 1, 1, 1, 1'b0, last_b, cut);
      apply_stimulus(1, cut);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end
endmodule

// File: doc/conv_layer_ctrl_param.md
CONV_LAYER_CTRL_PARAM -- requirements
Module: conv_layer_ctrl_param

Interface
REQ-001 SHALL have parameters: FILT_DEPTH, default 9, filter words loaded per filter; WIN_DEPTH, default 9, window words per temp fill; WR_SLOTS, default 4, results packed per memory write; NUM_FILT, default 2, filters processed per start; all four are ≥1.
REQ-002 SHALL have parameter CW, default 8, internal counter width; FW = clog2(NUM_FILT), min 1.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-004 SHALL have inputs (1 bit each): start (begin layer), doneAdr (address sweep finished), macDone (MAC window complete), emptyTemp (temp buffer exhausted).
REQ-005 SHALL have output sel (2 bits): memory address mux select, 00 = window address, 01 = filter address, 10 = write address, 11 = idle.
REQ-006 SHALL have 1-bit outputs: ldAdr, rstX, reMem, weMem, WEFilter, REFilter, rstFilter, WETemp, RETemp, rstTemp, WEview, REview, enCalc, rstCalc, ldWR, lastWR, rstWR, done, busy.
REQ-007 SHALL have output filtIdx (FW bits): index of the filter being processed.

Function
REQ-008 SHALL drive all strobes as Moore outputs decoded from the state register; any output not listed for a state is 0 and sel is 11.
REQ-009 SHALL assert busy in every state except IDLE.
REQ-010 IDLE: stays in IDLE until start=1, then goes to INIT; start is ignored in all other states.
REQ-011 INIT: asserts rstCalc, rstTemp, rstWR, ldAdr; clears filtIdx, fcnt, tcnt, wcnt; goes to LOAD_F.
REQ-012 LOAD_F: asserts WEFilter and reMem with sel=01; fcnt increments each cycle; when fcnt==FILT_DEPTH-1, clears fcnt and goes to RST_X (exactly FILT_DEPTH cycles).
REQ-013 RST_X: asserts rstX with sel=00; goes to LOAD_T.
REQ-014 LOAD_T: asserts WETemp and reMem with sel=00; tcnt increments; when tcnt==WIN_DEPTH-1, clears tcnt and goes to POP (exactly WIN_DEPTH cycles).
REQ-015 POP: asserts RETemp and rstCalc, then ARM; ARM asserts WEview and rstFilter, then MAC.
REQ-016 MAC: asserts enCalc, REview, REFilter; stays until macDone=1, then goes to CHK; macDone is ignored in all other states.
REQ-017 CHK: goes to LAST if doneAdr=1, else to PACK; doneAdr is sampled only in CHK.
REQ-018 PACK: asserts ldWR; if wcnt==WR_SLOTS-1, clears wcnt and goes to WRITE; otherwise increments wcnt and goes to ADV.
REQ-019 WRITE: asserts weMem with sel=10, then CLR; CLR asserts rstWR, then ADV.
REQ-020 ADV: goes to REFILL if emptyTemp=1, else to POP; REFILL asserts rstTemp, then RST_X.
REQ-021 LAST: asserts ldWR and lastWR, then FLUSH; FLUSH asserts weMem with sel=10 regardless of wcnt (a partial word is written), clears wcnt, then NEXTF.
REQ-022 NEXTF: if filtIdx==NUM_FILT-1, goes to DONE; otherwise increments filtIdx and goes to RELOAD.
REQ-023 RELOAD: asserts rstTemp, rstWR, rstCalc, ldAdr, then LOAD_F.
REQ-024 DONE: asserts done for exactly one cycle, then IDLE; filtIdx holds its last value until the next INIT.
REQ-025 WR_SLOTS=1: every PACK goes to WRITE and wcnt stays 0.
REQ-026 NUM_FILT=1: NEXTF always goes to DONE, and filtIdx is constant 0.
REQ-027 Counters are compared with equality only; they never exceed depth-1 and never wrap.
REQ-028 If macDone and doneAdr are both 1 in MAC, macDone alone is acted on; doneAdr takes effect in CHK only if it is still high there.

Reset
REQ-029 rst=1 at any time, including mid-operation, SHALL asynchronously force IDLE, clear fcnt, tcnt, wcnt and filtIdx, and drive all strobes 0, sel=11, busy=0, done=0.
REQ-030 After rst is released, no strobe SHALL assert until start=1 is sampled in IDLE.

Verification
REQ-031 Defaults, pulse start, hold macDone=1 and emptyTemp=0, doneAdr=0 -> WEFilter high 9 cycles with sel=01, rstX 1 cycle, WETemp high 9 cycles with sel=00.
REQ-032 Defaults, 8 MAC completions with doneAdr=0 -> ldWR 8 pulses, weMem/sel=10 after the 4th and 8th, rstWR after each write.
REQ-033 Defaults, doneAdr=1 at the 3rd CHK -> lastWR+ldWR, one weMem (partial), filtIdx 0→1, LOAD_F restarts; second pass ends with done 1 cycle, busy 0.
REQ-034 emptyTemp=1 at ADV -> rstTemp, rstX, then 9-cycle LOAD_T before the next POP.
REQ-035 rst asserted in the 5th LOAD_T cycle -> same-cycle outputs all 0, sel=11, busy=0; a new start gives a full 9-cycle LOAD_F and filtIdx=0.
REQ-036 NUM_FILT=1, WR_SLOTS=1 -> weMem after every PACK, and done follows the first FLUSH/NEXTF.
